sparc_data_path: RTL and testbench

Execution datapath slice of the SPARC V8 processor: instruction register, 32-entry integer register file, sign/shift extender, ALU operand multiplexers, 32-bit ALU with integer condition codes, and the PSR. It sits between the control unit, which drives every select, enable and register address, and the memory subsystem. It holds no sequencing state of its own.

---
 rtl/sparc_data_path_pkg.sv | 57 +++++
 rtl/sparc_data_path_if.sv | 44 ++++
 rtl/sparc_data_path_alu.sv | 60 ++++++
 rtl/sparc_data_path.sv | 102 ++++++++++
 tb/tb_sparc_data_path.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparc_data_path_pkg.sv
// Shared encodings for the SPARC V8 execution datapath: op3 codes, operand/extender selects, PSR layout.
// Pure definitions; no logic, no latency.
package sparc_data_path_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_AND  = 6'b000001;
    localparam logic [5:0] OP_OR   = 6'b000010;
    localparam logic [5:0] OP_XOR  = 6'b000011;
    localparam logic [5:0] OP_SUB  = 6'b000100;
    localparam logic [5:0] OP_ANDN = 6'b000101;
    localparam logic [5:0] OP_ORN  = 6'b000110;
    localparam logic [5:0] OP_XNOR = 6'b000111;
    localparam logic [5:0] OP_ADDX = 6'b001000;
    localparam logic [5:0] OP_SUBX = 6'b001100;
    localparam logic [5:0] OP_SLL  = 6'b100101;
    localparam logic [5:0] OP_SRL  = 6'b100110;
    localparam logic [5:0] OP_SRA  = 6'b100111;

    localparam logic [2:0] EXT_SIMM13 = 3'd0;
    localparam logic [2:0] EXT_SETHI  = 3'd1;
    localparam logic [2:0] EXT_DISP22 = 3'd2;
    localparam logic [2:0] EXT_DISP30 = 3'd3;

    localparam logic [2:0] ALUB_PB     = 3'd0;
    localparam logic [2:0] ALUB_EXT    = 3'd1;
    localparam logic [2:0] ALUB_FOUR   = 3'd2;
    localparam logic [2:0] ALUB_EIGHT  = 3'd3;

    typedef enum logic [1:0] {
        ALUA_PA   = 2'd0,
        ALUA_ZERO = 2'd1,
        ALUA_PSR  = 2'd2,
        ALUA_IR   = 2'd3
    } alua_sel_e;

    typedef enum logic [1:0] {
        PSR_SEL_ICC   = 2'd0,
        PSR_SEL_WRPSR = 2'd1,
        PSR_SEL_MODE  = 2'd2,
        PSR_SEL_HOLD  = 2'd3
    } psr_sel_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } icc_t;

    localparam int PSR_ICC_LSB = 20;
    localparam int PSR_C_BIT   = 20;
    localparam int PSR_S_BIT   = 7;
    localparam int PSR_PS_BIT  = 6;
    localparam int PSR_ET_BIT  = 5;
    localparam logic [31:0] PSR_MASK = 32'h00F0_00FF;

endpackage

// File: rtl/sparc_data_path_if.sv
// Control-side bundle for the datapath: selects, enables and addresses in, datapath observables out.
// Combinational wiring only; no flow control.
interface sparc_data_path_if;
    logic        IR_Enable;
    logic [31:0] IR_In;
    logic [31:0] IR_Out;
    logic        register_file_enable;
    logic [4:0]  in_PA;
    logic [4:0]  in_PB;
    logic [4:0]  in_PC;
    logic [31:0] out_PA;
    logic [31:0] out_PB;
    logic [2:0]  extender_select;
    logic [31:0] extender_out;
    logic [1:0]  ALUA_Mux_select;
    logic [2:0]  ALUB_Mux_select;
    logic [31:0] ALUA_Mux_out;
    logic [31:0] ALUB_Mux_out;
    logic [5:0]  ALU_op;
    logic [31:0] ALU_Out;
    logic        PSR_Enable;
    logic        PSR_Clr;
    logic [1:0]  PSR_Mux_select;
    logic        S;
    logic        PS;
    logic        ET;
    logic [31:0] PSR_out;

    modport master (
        output IR_Enable, IR_In, register_file_enable, in_PA, in_PB, in_PC,
               extender_select, ALUA_Mux_select, ALUB_Mux_select, ALU_op,
               PSR_Enable, PSR_Clr, PSR_Mux_select, S, PS, ET,
        input  IR_Out, out_PA, out_PB, extender_out, ALUA_Mux_out, ALUB_Mux_out,
               ALU_Out, PSR_out
    );

    modport slave (
        input  IR_Enable, IR_In, register_file_enable, in_PA, in_PB, in_PC,
               extender_select, ALUA_Mux_select, ALUB_Mux_select, ALU_op,
               PSR_Enable, PSR_Clr, PSR_Mux_select, S, PS, ET,
        output IR_Out, out_PA, out_PB, extender_out, ALUA_Mux_out, ALUB_Mux_out,
               ALU_Out, PSR_out
    );
endinterface

// File: rtl/sparc_data_path_alu.sv
// 32-bit SPARC integer ALU producing a result and NZVC; purely combinational, zero latency.
// No backpressure: output follows operands within the cycle.
module sparc_data_path_alu
    import sparc_data_path_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] result,
    output icc_t        icc
);
    logic [5:0]  base_op;
    logic [32:0] wide;
    logic        c_flag;
    logic        v_flag;
    logic        defined;

    always_comb begin
        // Bit 4 marks the cc variant of the arithmetic/logic group; shifts live above it.
        base_op = op[5] ? op : {op[5], 1'b0, op[3:0]};
        wide    = '0;
        result  = '0;
        c_flag  = 1'b0;
        v_flag  = 1'b0;
        defined = 1'b1;
        case (base_op)
            OP_ADD, OP_ADDX: begin
                wide   = {1'b0, a} + {1'b0, b} + {32'd0, (base_op == OP_ADDX) & carry_in};
                result = wide[31:0];
                c_flag = wide[32];
                v_flag = (a[31] == b[31]) && (result[31] != a[31]);
            end
            OP_SUB, OP_SUBX: begin
                wide   = {1'b0, a} - {1'b0, b} - {32'd0, (base_op == OP_SUBX) & carry_in};
                result = wide[31:0];
                c_flag = wide[32];
                v_flag = (a[31] != b[31]) && (result[31] != a[31]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ANDN: result = a & ~b;
            OP_ORN:  result = a | ~b;
            OP_XNOR: result = ~(a ^ b);
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            default: defined = 1'b0;
        endcase

        icc = '0;
        if (defined) begin
            icc.n = result[31];
            icc.z = (result == 32'd0);
            icc.v = v_flag;
            icc.c = c_flag;
        end
    end
endmodule

// File: rtl/sparc_data_path.sv
// SPARC V8 execution slice: IR, 32x32 register file, extender, operand muxes, ALU and PSR.
// State updates one cycle after the controlling selects; no backpressure, control owns all sequencing.
module sparc_data_path
    import sparc_data_path_pkg::*;
(
    input  logic              Clk,
    input  logic              RESET,
    sparc_data_path_if.slave  bus
);
    logic [31:0] ir_q;
    logic [31:0] psr_q;
    logic [31:0] psr_next;
    logic [31:0] regs [1:31];
    logic [31:0] ext_dat;
    logic [31:0] a_dat;
    logic [31:0] b_dat;
    logic [31:0] alu_dat;
    icc_t        alu_icc;

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET)              ir_q <= '0;
        else if (bus.IR_Enable) ir_q <= bus.IR_In;
    end

    // r0 has no storage: writes to it are dropped and reads are forced to zero.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else if (bus.register_file_enable && (bus.in_PC != 5'd0)) begin
            regs[bus.in_PC] <= alu_dat;
        end
    end

    assign bus.out_PA = (bus.in_PA == 5'd0) ? 32'd0 : regs[bus.in_PA];
    assign bus.out_PB = (bus.in_PB == 5'd0) ? 32'd0 : regs[bus.in_PB];

    always_comb begin
        case (bus.extender_select)
            EXT_SIMM13: ext_dat = {{19{ir_q[12]}}, ir_q[12:0]};
            EXT_SETHI:  ext_dat = {ir_q[21:0], 10'd0};
            EXT_DISP22: ext_dat = {{8{ir_q[21]}}, ir_q[21:0], 2'd0};
            EXT_DISP30: ext_dat = {ir_q[29:0], 2'd0};
            default:    ext_dat = '0;
        endcase
    end

    always_comb begin
        case (alua_sel_e'(bus.ALUA_Mux_select))
            ALUA_PA:   a_dat = bus.out_PA;
            ALUA_ZERO: a_dat = '0;
            ALUA_PSR:  a_dat = psr_q;
            ALUA_IR:   a_dat = ir_q;
            default:   a_dat = '0;
        endcase
    end

    always_comb begin
        case (bus.ALUB_Mux_select)
            ALUB_PB:    b_dat = bus.out_PB;
            ALUB_EXT:   b_dat = ext_dat;
            ALUB_FOUR:  b_dat = 32'd4;
            ALUB_EIGHT: b_dat = 32'd8;
            default:    b_dat = '0;
        endcase
    end

    sparc_data_path_alu u_alu (
        .op       (bus.ALU_op),
        .a        (a_dat),
        .b        (b_dat),
        .carry_in (psr_q[PSR_C_BIT]),
        .result   (alu_dat),
        .icc      (alu_icc)
    );

    always_comb begin
        psr_next = psr_q;
        case (psr_sel_e'(bus.PSR_Mux_select))
            PSR_SEL_ICC:   psr_next[PSR_ICC_LSB +: 4] = alu_icc;
            PSR_SEL_WRPSR: psr_next = alu_dat & PSR_MASK;
            PSR_SEL_MODE: begin
                psr_next[PSR_S_BIT]  = bus.S;
                psr_next[PSR_PS_BIT] = bus.PS;
                psr_next[PSR_ET_BIT] = bus.ET;
            end
            default:       psr_next = psr_q;
        endcase
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET)               psr_q <= '0;
        else if (bus.PSR_Clr)    psr_q <= '0;
        else if (bus.PSR_Enable) psr_q <= psr_next;
    end

    assign bus.IR_Out       = ir_q;
    assign bus.extender_out = ext_dat;
    assign bus.ALUA_Mux_out = a_dat;
    assign bus.ALUB_Mux_out = b_dat;
    assign bus.ALU_Out      = alu_dat;
    assign bus.PSR_out      = psr_q;
endmodule

// File: tb/tb_sparc_data_path.sv
// Scoreboard bench for sparc_data_path: expectations queued as stimulus is driven, popped as outputs settle.
module tb_sparc_data_path;
    import sparc_data_path_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sparc_data_path_if bus();

    sparc_data_path dut (
        .Clk   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic exp_c = 1'b0;

    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    // Reference ALU: returns {N,Z,V,C,result}; overflow judged from full-width signed arithmetic.
    function automatic logic [35:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin);
        logic [5:0]  base;
        logic [63:0] wide;
        longint      ss;
        logic [31:0] r;
        logic        c;
        logic        v;
        base = op;
        if (!op[5]) base[4] = 1'b0;
        r = '0; c = 1'b0; v = 1'b0; wide = '0; ss = 0;
        case (base)
            6'b000000, 6'b001000: begin
                wide = 64'(a) + 64'(b) + ((base == 6'b001000) ? 64'(cin) : 64'd0);
                r    = wide[31:0];
                c    = wide[32];
                ss   = longint'($signed(a)) + longint'($signed(b))
                     + ((base == 6'b001000) ? longint'(cin) : 0);
                v    = (ss > SMAX) || (ss < SMIN);
            end
            6'b000100, 6'b001100: begin
                wide = 64'(a) - 64'(b) - ((base == 6'b001100) ? 64'(cin) : 64'd0);
                r    = wide[31:0];
                c    = 64'(a) < (64'(b) + ((base == 6'b001100) ? 64'(cin) : 64'd0));
                ss   = longint'($signed(a)) - longint'($signed(b))
                     - ((base == 6'b001100) ? longint'(cin) : 0);
                v    = (ss > SMAX) || (ss < SMIN);
            end
            6'b000001: r = a & b;
            6'b000010: r = a | b;
            6'b000011: r = a ^ b;
            6'b000101: r = a & ~b;
            6'b000110: r = a | ~b;
            6'b000111: r = ~(a ^ b);
            6'b100101: r = a << b[4:0];
            6'b100110: r = a >> b[4:0];
            6'b100111: r = 32'($signed(a) >>> b[4:0]);
            default:   return 36'd0;
        endcase
        return {r[31], (r == 32'd0), v, c, r};
    endfunction

    function automatic logic [31:0] ext_model(input logic [31:0] w, input int sel);
        case (sel)
            0:       return 32'($signed(w[12:0]));
            1:       return w << 10;
            2:       return 32'($signed(w[21:0])) << 2;
            3:       return w << 2;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        bus.IR_Enable = 0; bus.IR_In = '0; bus.register_file_enable = 0;
        bus.in_PA = '0; bus.in_PB = '0; bus.in_PC = '0;
        bus.extender_select = '0; bus.ALUA_Mux_select = '0; bus.ALUB_Mux_select = '0;
        bus.ALU_op = '0; bus.PSR_Enable = 0; bus.PSR_Clr = 0; bus.PSR_Mux_select = 2'd3;
        bus.S = 0; bus.PS = 0; bus.ET = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic commit();
        step();
        bus.register_file_enable = 0; bus.PSR_Enable = 0; bus.PSR_Clr = 0; bus.IR_Enable = 0;
    endtask

    task automatic load_ir(input logic [31:0] w);
        bus.IR_In = w; bus.IR_Enable = 1;
        step();
        bus.IR_Enable = 0;
    endtask

    task automatic drive(input logic [5:0] op, input logic [1:0] asel, input logic [2:0] bsel,
                         input logic [2:0] esel, input logic [4:0] pa, input logic [4:0] pb,
                         input logic [4:0] pc, input logic rf_en, input logic psr_en,
                         input logic [1:0] psel);
        bus.ALU_op = op; bus.ALUA_Mux_select = asel; bus.ALUB_Mux_select = bsel;
        bus.extender_select = esel; bus.in_PA = pa; bus.in_PB = pb; bus.in_PC = pc;
        bus.register_file_enable = rf_en; bus.PSR_Enable = psr_en; bus.PSR_Mux_select = psel;
    endtask

    task automatic test_reset();
        sb.push_back('{"rst_ir", 32'h0});
        sb.push_back('{"rst_psr", 32'h0});
        sb.push_back('{"rst_ext", 32'h0});
        sb.push_back('{"rst_alu", 32'h0});
        e = sb.pop_front(); checks++;
        if (bus.IR_Out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.IR_Out, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.PSR_out, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.extender_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.extender_out, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.ALU_Out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALU_Out, e.val); end
    endtask

    task automatic test_add_nocc();
        load_ir(32'h82002000);
        drive(OP_ADD, 2'd0, 3'd1, 3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 2'd0);
        sb.push_back('{"add_alu", 32'h0});
        #2;
        e = sb.pop_front(); checks++;
        if (bus.ALU_Out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALU_Out, e.val); end
        commit();
        sb.push_back('{"add_r1", 32'h0});
        sb.push_back('{"add_psr", 32'h0});
        bus.in_PA = 5'd1; #1;
        e = sb.pop_front(); checks++;
        if (bus.out_PA !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.out_PA, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.PSR_out, e.val); end
    endtask

    task automatic test_addcc();
        load_ir(32'h82803FFF);
        drive(6'b010000, 2'd0, 3'd1, 3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 2'd0);
        sb.push_back('{"addcc_ext", 32'hFFFF_FFFF});
        sb.push_back('{"addcc_alu", 32'hFFFF_FFFF});
        #2;
        e = sb.pop_front(); checks++;
        if (bus.extender_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.extender_out, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.ALU_Out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALU_Out, e.val); end
        commit();
        sb.push_back('{"addcc_r1", 32'hFFFF_FFFF});
        sb.push_back('{"addcc_psr", 32'h0080_0000});
        bus.in_PA = 5'd1; #1;
        e = sb.pop_front(); checks++;
        if (bus.out_PA !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.out_PA, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.PSR_out, e.val); end
    endtask

    task automatic test_addcc_carry();
        load_ir(32'h84002001);
        drive(OP_ADD, 2'd0, 3'd1, 3'd0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 2'd0);
        commit();
        drive(6'b010000, 2'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 2'd0);
        sb.push_back('{"carry_a", 32'hFFFF_FFFF});
        sb.push_back('{"carry_b", 32'h1});
        sb.push_back('{"carry_alu", 32'h0});
        #2;
        e = sb.pop_front(); checks++;
        if (bus.ALUA_Mux_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALUA_Mux_out, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.ALUB_Mux_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALUB_Mux_out, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.ALU_Out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALU_Out, e.val); end
        commit();
        sb.push_back('{"carry_r2", 32'h0});
        sb.push_back('{"carry_psr", 32'h0050_0000});
        bus.in_PA = 5'd2; #1;
        e = sb.pop_front(); checks++;
        if (bus.out_PA !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.out_PA, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.PSR_out, e.val); end
    endtask

    task automatic test_subcc_overflow();
        load_ir(32'h0020_0000);
        drive(OP_ADD, 2'd1, 3'd1, 3'd1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 2'd0);
        sb.push_back('{"sethi_alu", 32'h8000_0000});
        #2;
        e = sb.pop_front(); checks++;
        if (bus.ALU_Out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALU_Out, e.val); end
        commit();
        load_ir(32'h0000_0001);
        drive(6'b010100, 2'd0, 3'd1, 3'd0, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 2'd0);
        commit();
        sb.push_back('{"subcc_r4", 32'h7FFF_FFFF});
        sb.push_back('{"subcc_psr", 32'h0020_0000});
        bus.in_PA = 5'd4; #1;
        e = sb.pop_front(); checks++;
        if (bus.out_PA !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.out_PA, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.PSR_out, e.val); end
    endtask

    task automatic test_r0_write();
        load_ir(32'h0000_0005);
        drive(OP_ADD, 2'd1, 3'd1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0);
        commit();
        sb.push_back('{"r0_pa", 32'h0});
        sb.push_back('{"r0_pb", 32'h0});
        bus.in_PA = 5'd0; bus.in_PB = 5'd0; #1;
        e = sb.pop_front(); checks++;
        if (bus.out_PA !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.out_PA, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.out_PB !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.out_PB, e.val); end
    endtask

    task automatic test_extender();
        logic [31:0] words [4];
        words[0] = 32'h0020_1000; words[1] = 32'hFFDF_EFFF;
        words[2] = $urandom;      words[3] = $urandom;
        for (int w = 0; w < 4; w++) begin
            load_ir(words[w]);
            bus.ALUA_Mux_select = 2'd3;
            sb.push_back('{"ir_via_alua", words[w]});
            #1;
            e = sb.pop_front(); checks++;
            if (bus.ALUA_Mux_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALUA_Mux_out, e.val); end
            for (int s = 0; s < 8; s++) begin
                bus.extender_select = 3'(s);
                sb.push_back('{$sformatf("ext_sel%0d", s), ext_model(words[w], s)});
                #1;
                e = sb.pop_front(); checks++;
                if (bus.extender_out !== e.val) begin errors++; $display("FAIL %s: ir %h got %h want %h", e.name, words[w], bus.extender_out, e.val); end
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [5:0]  ops [15];
        logic [31:0] words [4];
        logic [35:0] m;
        logic [5:0]  opc;
        ops = '{OP_ADD, OP_AND, OP_OR, OP_XOR, OP_SUB, OP_ANDN, OP_ORN, OP_XNOR,
                OP_ADDX, OP_SUBX, OP_SLL, OP_SRL, OP_SRA, 6'b001001, 6'b111111};
        words[0] = 32'hFFFF_FFFF; words[1] = 32'h8000_1003;
        words[2] = $urandom;      words[3] = $urandom;
        bus.PSR_Clr = 1; commit();
        exp_c = 1'b0;
        for (int w = 0; w < 4; w++) begin
            load_ir(words[w]);
            for (int k = 0; k < 15; k++) begin
                opc = ops[k][5] ? ops[k] : (ops[k] | 6'b010000);
                m = alu_model(opc, words[w], ext_model(words[w], 0), exp_c);
                drive(opc, 2'd3, 3'd1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 2'd0);
                sb.push_back('{$sformatf("alu_op%b", opc), m[31:0]});
                #2;
                e = sb.pop_front(); checks++;
                if (bus.ALU_Out !== e.val) begin errors++; $display("FAIL %s: ir %h got %h want %h", e.name, words[w], bus.ALU_Out, e.val); end
                commit();
                sb.push_back('{$sformatf("icc_op%b", opc), {8'h0, m[35:32], 20'h0}});
                exp_c = m[32];
                e = sb.pop_front(); checks++;
                if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: ir %h got %h want %h", e.name, words[w], bus.PSR_out, e.val); end
            end
        end
    endtask

    task automatic test_psr_fields();
        logic [31:0] bconst [8];
        bconst = '{32'h0, 32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0};
        bus.PSR_Clr = 1; commit();
        for (int s = 2; s < 8; s++) begin
            bus.ALUB_Mux_select = 3'(s);
            sb.push_back('{$sformatf("alub_sel%0d", s), bconst[s]});
            #1;
            e = sb.pop_front(); checks++;
            if (bus.ALUB_Mux_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALUB_Mux_out, e.val); end
        end
        bus.S = 1; bus.PS = 0; bus.ET = 1;
        drive(OP_ADD, 2'd2, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 2'd2);
        commit();
        drive(OP_ADD, 2'd2, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 2'd3);
        sb.push_back('{"psr_via_alua", 32'h0000_00A0});
        #1;
        e = sb.pop_front(); checks++;
        if (bus.ALUA_Mux_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.ALUA_Mux_out, e.val); end
        commit();
        sb.push_back('{"psr_hold", 32'h0000_00A0});
        e = sb.pop_front(); checks++;
        if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.PSR_out, e.val); end
        drive(OP_ADD, 2'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 2'd2);
        bus.PSR_Clr = 1; bus.S = 0; bus.ET = 0; bus.PS = 1;
        commit();
        sb.push_back('{"psr_clr_priority", 32'h0});
        e = sb.pop_front(); checks++;
        if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.PSR_out, e.val); end
        load_ir(32'hFFFF_FFFF);
        drive(OP_OR, 2'd3, 3'd4, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 2'd1);
        commit();
        sb.push_back('{"wrpsr", 32'h00F0_00FF});
        e = sb.pop_front(); checks++;
        if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.PSR_out, e.val); end
        bus.PS = 0;
        bus.PSR_Clr = 1; commit();
    endtask

    task automatic test_rw_same();
        load_ir(32'h0000_0123);
        drive(OP_ADD, 2'd1, 3'd1, 3'd0, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 2'd3);
        sb.push_back('{"rw_old", 32'h0});
        #2;
        e = sb.pop_front(); checks++;
        if (bus.out_PA !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.out_PA, e.val); end
        commit();
        sb.push_back('{"rw_new", 32'h123});
        e = sb.pop_front(); checks++;
        if (bus.out_PA !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.out_PA, e.val); end
    endtask

    task automatic test_reset_midrun();
        load_ir(32'h0000_0777);
        drive(OP_ADD, 2'd1, 3'd1, 3'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 2'd1);
        commit();
        #2 rst = 1; #1;
        sb.push_back('{"mid_ir", 32'h0});
        sb.push_back('{"mid_psr", 32'h0});
        e = sb.pop_front(); checks++;
        if (bus.IR_Out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.IR_Out, e.val); end
        e = sb.pop_front(); checks++;
        if (bus.PSR_out !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.PSR_out, e.val); end
        for (int r = 1; r < 32; r++) begin
            bus.in_PA = 5'(r);
            sb.push_back('{$sformatf("mid_r%0d", r), 32'h0});
            #0.1;
            e = sb.pop_front(); checks++;
            if (bus.out_PA !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, bus.out_PA, e.val); end
        end
        @(negedge clk); rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        idle();
        #3;
        test_reset();
        @(negedge clk); rst = 0;
        step();
        test_add_nocc();
        test_addcc();
        test_addcc_carry();
        test_subcc_overflow();
        test_r0_write();
        test_extender();
        test_alu_ops();
        test_psr_fields();
        test_rw_same();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
